// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares the single KGP-RISC memory
// port between instruction fetch (requester 0) and load/store (requester 1).
// A grant is held while its owner keeps requesting. Grants, select, busy and
// preempt are all registered.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a hold counter
// forces a handoff once the owner has held the port for MAX_HOLD cycles while
// the other requester waits.
module mem_port_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy,
  output logic preempt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  // Reject parameter sets the hold counter cannot represent.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_bad_cfg
    $error("mem_port_arbiter: MAX_HOLD must be 2..255 and below 2**CNT_W");
  end

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   gnt0_q, gnt0_d;
  logic   gnt1_q, gnt1_d;
  logic   sel_q, sel_d;
  logic   busy_q, busy_d;
  logic   preempt_q, preempt_d;
  logic   hold_expired;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The owner has used up its hold budget.
  always_comb begin
    hold_expired = (cnt_q == MAX_HOLD_C);
  end

  // Hold counter: zero on every grant entry, counts while granted, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q != IDLE) && (cnt_q != MAX_HOLD_C)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without forced preemption a grant is never revoked early.
  always_comb begin
    hold_expired = 1'b0;
  end
`endif

  // Next-state logic. The next-cycle outputs are decoded from the next state.
  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? G0 : G1;
        end else if (req0) begin
          state_d = G0;
        end else if (req1) begin
          state_d = G1;
        end else begin
          state_d = IDLE;
        end
      end
      G0: begin
        if (req0) begin
          if (hold_expired && req1) begin
            state_d   = G1;
            preempt_d = 1'b1;
          end else begin
            state_d = G0;
          end
        end else if (req1) begin
          state_d = G1;
        end else begin
          state_d = IDLE;
        end
      end
      G1: begin
        if (req1) begin
          if (hold_expired && req0) begin
            state_d   = G0;
            preempt_d = 1'b1;
          end else begin
            state_d = G1;
          end
        end else if (req0) begin
          state_d = G0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // In IDLE, sel keeps pointing at the previous owner.
    if (state_d == G0) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (state_d == G1) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end else begin
      last_d = last_q;
      sel_d  = sel_q;
    end
    gnt0_d = (state_d == G0);
    gnt1_d = (state_d == G1);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs. last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A behavioural owner/age model sets the
// expected values. The bench runs directed scenarios and then random traffic.
module tb_mem_port_arbiter;

  localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b1;
  logic req1 = 1'b1;
  logic gnt0, gnt1, sel, busy, preempt;

  int checks = 0;
  int failures = 0;

  // Reference model: owner (-1 means none), previous winner, grant age
  // (cycles since the grant began), current select value, and preempt flag.
  int m_owner, m_last, m_age, m_sel, m_pre;

  // Fairness bookkeeping, taken from the observed DUT grants.
  int wait_grants [2];
  int max_wait_grants [2];
  bit prev_gnt [2];

  mem_port_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_age = 0; m_sel = 0; m_pre = 0;
    for (int i = 0; i < 2; i++) begin
      wait_grants[i] = 0;
      prev_gnt[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit r0, input bit r1);
    int nxt;
    bit mine, other;
    m_pre = 0;
    if (m_owner < 0) begin
      if (r0 && r1) nxt = 1 - m_last;
      else if (r0)  nxt = 0;
      else if (r1)  nxt = 1;
      else          nxt = -1;
    end else begin
      mine  = (m_owner == 0) ? r0 : r1;
      other = (m_owner == 0) ? r1 : r0;
      if (mine) begin
        if (TO_EN && (m_age >= MAX_HOLD) && other) begin
          nxt = 1 - m_owner;
          m_pre = 1;
        end else begin
          nxt = m_owner;
        end
      end else if (other) begin
        nxt = 1 - m_owner;
      end else begin
        nxt = -1;
      end
    end
    if (nxt >= 0 && nxt != m_owner) begin
      m_age = 0;
      m_last = nxt;
    end else if (nxt >= 0) begin
      m_age++;
    end
    if (nxt >= 0) m_sel = nxt;
    m_owner = nxt;
  endtask

  task automatic compare_all();
    bit g [2];
    bit r [2];
    check("gnt0", int'(gnt0), int'(m_owner == 0));
    check("gnt1", int'(gnt1), int'(m_owner == 1));
    check("sel", int'(sel), m_sel);
    check("busy", int'(busy), int'(m_owner >= 0));
    check("preempt", int'(preempt), m_pre);
    check("mutex", int'(gnt0 & gnt1), 0);
    // Count how many new grants of the other side a waiting requester sits through.
    g[0] = gnt0; g[1] = gnt1; r[0] = req0; r[1] = req1;
    for (int i = 0; i < 2; i++) begin
      if (r[i] && !g[i]) begin
        if (g[1-i] && !prev_gnt[1-i]) wait_grants[i]++;
      end else begin
        wait_grants[i] = 0;
      end
      if (wait_grants[i] > max_wait_grants[i]) max_wait_grants[i] = wait_grants[i];
    end
    prev_gnt[0] = g[0]; prev_gnt[1] = g[1];
  endtask

  // Drive requests (called at a negedge), clock once, then check at the next negedge.
  task automatic cyc(input bit r0, input bit r1);
    req0 = r0;
    req1 = r1;
    @(posedge clk);
    model_step(r0, r1);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit r0, r1;
    max_wait_grants[0] = 0;
    max_wait_grants[1] = 0;
    model_reset();

    // Reset held with both requests high.
    #12;
    check("rst_gnt0", int'(gnt0), 0);
    check("rst_gnt1", int'(gnt1), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_preempt", int'(preempt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1);
    check("first_tie_gnt0", int'(gnt0), 1);
    check("first_tie_sel", int'(sel), 0);

    // Tie with last=0 goes to requester 1, then a direct handoff back to 0.
    cyc(1'b0, 1'b0);
    check("idle_busy", int'(busy), 0);
    cyc(1'b1, 1'b1);
    check("tie_gnt1", int'(gnt1), 1);
    check("tie_sel", int'(sel), 1);
    cyc(1'b1, 1'b0);
    check("handoff_gnt0", int'(gnt0), 1);
    check("handoff_sel", int'(sel), 0);

    // A long hold with no competition is never preempted.
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0);
      check("hold_gnt0", int'(gnt0), 1);
    end

    // The competitor arrives on the grant's second cycle.
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    check("after_drop_gnt1", int'(gnt1), 1);

    // Asynchronous reset between edges while in G1.
    check("pre_async_sel", int'(sel), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt1", int'(gnt1), 0);
    check("async_sel", int'(sel), 0);
    check("async_busy", int'(busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    check("post_rst_gnt1", int'(gnt1), 1);

    // Random traffic with sticky requests.
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(99) < 15) r0 = ~r0;
      if ($urandom_range(99) < 15) r1 = ~r1;
      cyc(r0, r1);
    end
    check("fair0", int'(max_wait_grants[0] <= 1), 1);
    check("fair1", int'(max_wait_grants[1] <= 1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
